// File: rtl/basketball_pkg.sv
// Shared state encoding, BCD shot-clock constants and BCD compare helper
// for the shot-clock sequencer.
package basketball_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [7:0] SHOT_FULL  = 8'h24;
  localparam logic [7:0] SHOT_SHORT = 8'h14;
  localparam logic [7:0] SHOT_ZERO  = 8'h00;

  // Two-digit BCD a < b, tens digit decides unless equal
  function automatic logic bcd_lt(input logic [7:0] a, input logic [7:0] b);
    if (a[7:4] != b[7:4]) return (a[7:4] < b[7:4]);
    return (a[3:0] < b[3:0]);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// One-second strobe prescaler: counts 0..TICK_DIV-1 while run is high,
// holds its partial count when run is low, clears on clr.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic cp,
  input  logic nrest,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre;

  always_ff @(posedge cp or negedge nrest) begin
    if (!nrest) begin
      pre <= '0;
    end else if (clr) begin
      pre <= '0;
    end else if (run) begin
      pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
    end
  end

  assign tick = run && !clr && (pre == PRE_LAST);

endmodule

// File: rtl/shot_clock_ctrl.sv
// Shot-clock run/stop sequencer: referee buttons, one-second decrement strobe,
// reload commands to the BCD counter, expiry detection and horn timing.
module shot_clock_ctrl
  import basketball_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int BUZZ_LEN = 100000000
) (
  input  logic       cp,
  input  logic       nrest,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_r24,
  input  logic       btn_r14,
  input  logic [3:0] cnt_h,
  input  logic [3:0] cnt_l,
  output logic       dec_en,
  output logic       load,
  output logic [7:0] load_val,
  output logic       running,
  output logic       buzzer
);

  localparam int HW = (BUZZ_LEN > 1) ? $clog2(BUZZ_LEN) : 1;
  localparam logic [HW-1:0] HORN_LAST = HW'(BUZZ_LEN - 1);

  state_t        state, state_nx;
  logic [7:0]    cnt;
  logic [7:0]    load_val_nx;
  logic [HW-1:0] horn, horn_nx;
  logic          r14_ok, stop_act, start_act;
  logic          load_act, expire_act, tick, dec_nx;

  assign cnt    = {cnt_h, cnt_l};
  assign r14_ok = bcd_lt(cnt, SHOT_SHORT);

  // Any reload button outranks stop/start, even a short reload that does nothing
  assign stop_act  = btn_stop && !btn_r24 && !btn_r14;
  assign start_act = btn_start && !btn_stop && !btn_r24 && !btn_r14;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .cp    (cp),
    .nrest (nrest),
    .run   (state == ST_RUN),
    .clr   (load_act || expire_act),
    .tick  (tick)
  );

  always_comb begin
    state_nx    = state;
    load_act    = 1'b0;
    load_val_nx = load_val;
    expire_act  = 1'b0;
    horn_nx     = '0;

    if (btn_r24) begin
      load_act    = 1'b1;
      load_val_nx = SHOT_FULL;
    end else if (btn_r14 && r14_ok) begin
      load_act    = 1'b1;
      load_val_nx = SHOT_SHORT;
    end

    if (load_act) begin
      state_nx = ST_STOPPED;
    end else begin
      case (state)
        ST_STOPPED: if (start_act && (cnt != SHOT_ZERO)) state_nx = ST_RUN;
        ST_RUN: begin
          if (cnt == SHOT_ZERO) begin
            expire_act = 1'b1;
            state_nx   = ST_EXPIRED;
          end else if (stop_act) begin
            state_nx = ST_STOPPED;
          end
        end
        ST_EXPIRED: begin
          if (horn == HORN_LAST) state_nx = ST_DONE;
          else                   horn_nx  = horn + 1'b1;
        end
        ST_DONE:    state_nx = ST_DONE;
        default:    state_nx = ST_STOPPED;
      endcase
    end

    // A stop on the terminal prescaler cycle still completes that second
    dec_nx = tick && (cnt != SHOT_ZERO) && !load_act;
  end

  always_ff @(posedge cp or negedge nrest) begin
    if (!nrest) begin
      state    <= ST_STOPPED;
      horn     <= '0;
      dec_en   <= 1'b0;
      load     <= 1'b0;
      load_val <= SHOT_FULL;
      running  <= 1'b0;
      buzzer   <= 1'b0;
    end else begin
      state    <= state_nx;
      horn     <= horn_nx;
      dec_en   <= dec_nx;
      load     <= load_act;
      load_val <= load_val_nx;
      running  <= (state_nx == ST_RUN);
      buzzer   <= (state_nx == ST_EXPIRED);
    end
  end

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Directed bench for shot_clock_ctrl with a behavioural BCD shot counter
// closing the loop on dec_en/load.
module tb_shot_clock_ctrl;

  logic       cp;
  logic       nrest;
  logic       btn_start, btn_stop, btn_r24, btn_r14;
  logic [3:0] cnt_h, cnt_l;
  logic       dec_en, load, running, buzzer;
  logic [7:0] load_val;
  logic [7:0] cnt_m;

  int n_assert = 0;
  int n_fail   = 0;
  int dec_at_zero = 0;
  int dec_and_load = 0;
  int load_cycles = 0;

  shot_clock_ctrl #(
    .TICK_DIV (4),
    .BUZZ_LEN (6)
  ) dut (
    .cp        (cp),
    .nrest     (nrest),
    .btn_start (btn_start),
    .btn_stop  (btn_stop),
    .btn_r24   (btn_r24),
    .btn_r14   (btn_r14),
    .cnt_h     (cnt_h),
    .cnt_l     (cnt_l),
    .dec_en    (dec_en),
    .load      (load),
    .load_val  (load_val),
    .running   (running),
    .buzzer    (buzzer)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  // Behavioural BCD shot counter
  always @(posedge cp or negedge nrest) begin
    if (!nrest) cnt_m <= 8'h24;
    else if (load) cnt_m <= load_val;
    else if (dec_en && cnt_m != 8'h00) begin
      if (cnt_m[3:0] == 4'h0) cnt_m <= {cnt_m[7:4] - 4'h1, 4'h9};
      else                    cnt_m <= {cnt_m[7:4], cnt_m[3:0] - 4'h1};
    end
  end
  assign cnt_h = cnt_m[7:4];
  assign cnt_l = cnt_m[3:0];

  always @(posedge cp) begin
    if (nrest) begin
      if (dec_en && cnt_m == 8'h00) dec_at_zero++;
      if (dec_en && load) dec_and_load++;
      if (load) load_cycles++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge cp);
    #1;
  endtask

  initial begin
    nrest = 1'b0; btn_start = 0; btn_stop = 0; btn_r24 = 0; btn_r14 = 0;
    step(3);
    chk("rst_running", running, 0);
    chk("rst_buzzer", buzzer, 0);
    chk("rst_dec_en", dec_en, 0);
    chk("rst_load", load, 0);
    chk("rst_load_val", load_val, 8'h24);
    nrest = 1'b1;
    step(2);

    // Start from 24; first strobe TICK_DIV cycles after entering RUN
    btn_start = 1; step(1); btn_start = 0;
    chk("start_running", running, 1);
    step(3);
    chk("pre_first_dec", dec_en, 0);
    step(1);
    chk("first_dec", dec_en, 1);
    chk("first_dec_cnt", cnt_m, 8'h24);
    step(1);
    chk("first_dec_width", dec_en, 0);
    chk("cnt_23", cnt_m, 8'h23);
    step(4); chk("cnt_22", cnt_m, 8'h22);
    step(4); chk("cnt_21", cnt_m, 8'h21);
    step(4); chk("cnt_20", cnt_m, 8'h20);
    step(4); chk("cnt_19_borrow", cnt_m, 8'h19);
    step(4); chk("cnt_18", cnt_m, 8'h18);
    btn_r14 = 1; step(1); btn_r14 = 0;
    chk("r14_at18_noload", load, 0);
    chk("r14_at18_running", running, 1);
    chk("no_load_in_run", load_cycles, 0);

    // Run down to expiry
    step(70);
    chk("cnt_01", cnt_m, 8'h01);
    chk("last_dec", dec_en, 1);
    step(1);
    chk("cnt_00", cnt_m, 8'h00);
    chk("buzz_not_yet", buzzer, 0);
    chk("run_at_00", running, 1);
    step(1);
    for (int i = 0; i < 6; i++) begin
      chk("buzz_on", buzzer, 1);
      chk("expired_not_running", running, 0);
      step(1);
    end
    chk("buzz_off_done", buzzer, 0);
    chk("done_running", running, 0);
    btn_start = 1; step(1); btn_start = 0;
    step(2);
    chk("done_start_ignored", running, 0);
    chk("done_no_load", load, 0);
    chk("no_dec_at_00", dec_at_zero, 0);

    // Reload 24 from DONE, run to 09, short reload
    btn_r24 = 1; step(1); btn_r24 = 0;
    chk("done_r24_load", load, 1);
    chk("done_r24_val", load_val, 8'h24);
    step(1);
    chk("done_r24_cnt", cnt_m, 8'h24);
    btn_start = 1; step(1); btn_start = 0;
    step(61);
    chk("cnt_09", cnt_m, 8'h09);
    chk("run_09", running, 1);
    btn_r14 = 1; step(1); btn_r14 = 0;
    chk("r14_load", load, 1);
    chk("r14_val", load_val, 8'h14);
    chk("r14_stopped", running, 0);
    chk("r14_no_dec", dec_en, 0);
    step(1);
    chk("r14_cnt", cnt_m, 8'h14);
    chk("r14_load_width", load, 0);

    // Stop after two prescaler cycles keeps the partial second
    btn_start = 1; step(1); btn_start = 0;
    step(1);
    btn_stop = 1; step(1); btn_stop = 0;
    chk("stop_running", running, 0);
    step(10);
    chk("idle_cnt", cnt_m, 8'h14);
    chk("idle_dec", dec_en, 0);
    btn_start = 1; step(1); btn_start = 0;
    chk("restart_running", running, 1);
    chk("restart_dec0", dec_en, 0);
    step(1);
    chk("restart_dec1", dec_en, 0);
    step(1);
    chk("restart_dec2", dec_en, 1);
    step(1);
    chk("restart_cnt13", cnt_m, 8'h13);

    // Simultaneous r24 + r14 + start in RUN
    btn_r24 = 1; btn_r14 = 1; btn_start = 1; step(1);
    btn_r24 = 0; btn_r14 = 0; btn_start = 0;
    chk("multi_load", load, 1);
    chk("multi_val", load_val, 8'h24);
    chk("multi_running", running, 0);
    step(1);
    chk("multi_single_load", load, 0);
    chk("multi_cnt", cnt_m, 8'h24);
    chk("multi_still_stopped", running, 0);

    // Horn aborted by r24 in its third cycle
    btn_start = 1; step(1); btn_start = 0;
    step(97);
    chk("abort_cnt00", cnt_m, 8'h00);
    step(1);
    chk("abort_buzz1", buzzer, 1);
    step(2);
    chk("abort_buzz3", buzzer, 1);
    btn_r24 = 1; step(1); btn_r24 = 0;
    chk("abort_buzz_off", buzzer, 0);
    chk("abort_load", load, 1);
    chk("abort_val", load_val, 8'h24);
    step(1);
    chk("abort_cnt24", cnt_m, 8'h24);
    chk("abort_stays_off", buzzer, 0);

    // Asynchronous reset mid-RUN
    btn_start = 1; step(1); btn_start = 0;
    step(4);
    chk("prerst_dec", dec_en, 1);
    chk("prerst_running", running, 1);
    nrest = 1'b0;
    #2;
    chk("arst_running", running, 0);
    chk("arst_dec_en", dec_en, 0);
    chk("arst_load", load, 0);
    chk("arst_buzzer", buzzer, 0);
    chk("arst_load_val", load_val, 8'h24);
    step(2);
    nrest = 1'b1;
    step(2);
    chk("post_rst_running", running, 0);
    chk("post_rst_buzzer", buzzer, 0);
    chk("post_rst_cnt", cnt_m, 8'h24);

    chk("dec_load_exclusive", dec_and_load, 0);
    chk("never_dec_at_00", dec_at_zero, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
